// File: rtl/stats_pkg.sv
// stats_pkg: shared widths, FSM state type and response beat layout for the stats read engine.
package stats_pkg;
  localparam int STATS_ADDR_W = 16;
  localparam int STATS_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERR} stats_reader_state_t;
  typedef struct packed {
    logic [STATS_DATA_W-1:0] data;
    logic last;
    logic err;
  } stats_beat_t;
  localparam int STATS_BEAT_W = $bits(stats_beat_t);
endpackage

// File: rtl/stats_reader_fifo.sv
// stats_reader_fifo: shift-register FIFO; entry 0 is the head, so the head is always a flop output.
module stats_reader_fifo import stats_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [STATS_BEAT_W-1:0] din,
  output logic [STATS_BEAT_W-1:0] head,
  output logic [CW-1:0]           count
);
  stats_beat_t q [DEPTH];
  stats_beat_t nxt [DEPTH];
  logic [CW-1:0] wr;
  always_comb begin
    nxt = q;
    wr = count - CW'(pop);
    if (pop) for (int i = 0; i < DEPTH - 1; i++) nxt[i] = q[i+1];
    for (int i = 0; i < DEPTH; i++) if (push && wr == CW'(i)) nxt[i] = stats_beat_t'(din);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{default: '0};
      count <= '0;
    end else begin
      q <= nxt;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = q[0];
endmodule

// File: rtl/stats_reader.sv
// stats_reader: burst read engine for the counter memory, compensating the fixed read latency.
// Define STATS_READER_CLR_EN to add clear-on-read outputs clr_valid/clr_addr.
module stats_reader import stats_pkg::*; #(
  parameter int NUM_COUNTERS = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [STATS_ADDR_W-1:0] req_addr,
  input  logic [7:0]              req_len,
  output logic [STATS_ADDR_W-1:0] raddr,
  input  logic [STATS_DATA_W-1:0] rdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [STATS_DATA_W-1:0] resp_data,
  output logic                    resp_last,
  output logic                    resp_err
`ifdef STATS_READER_CLR_EN
  ,
  output logic                    clr_valid,
  output logic [STATS_ADDR_W-1:0] clr_addr
`endif
);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  stats_reader_state_t state, next_state;
  logic [7:0] rem;
  logic [READ_LATENCY-1:0] vp, lp;
  logic [CW-1:0] fcount;
  logic [STATS_BEAT_W-1:0] head_bits;
  stats_beat_t head;
  logic accept, range_err, issue, pop, err_st, fifo_nonempty;
  stats_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(vp[READ_LATENCY-1]),
    .pop(pop),
    .din({rdata, lp[READ_LATENCY-1], 1'b0}),
    .head(head_bits),
    .count(fcount)
  );
  assign head = stats_beat_t'(head_bits);
  // Credits count FIFO entries plus reads still in the tag pipe, so the FIFO can never overflow.
  always_comb begin
    err_st = state == ERR;
    fifo_nonempty = fcount != '0;
    req_ready = state == IDLE && !reset;
    accept = req_valid && req_ready;
    range_err = {1'b0, req_addr} + 17'(req_len) + 17'd1 > 17'(NUM_COUNTERS);
    issue = state == ISSUE && int'(fcount) + $countones(vp) < FIFO_DEPTH;
    pop = fifo_nonempty && resp_ready && !err_st;
    resp_valid = err_st || fifo_nonempty;
    resp_data = err_st ? '0 : head.data;
    resp_last = err_st || (fifo_nonempty && head.last);
    resp_err = err_st || (fifo_nonempty && head.err);
    next_state = state == IDLE  ? (accept ? (range_err ? ERR : ISSUE) : IDLE) :
                 state == ISSUE ? (issue && rem == '0 ? DRAIN : ISSUE) :
                 state == DRAIN ? (vp == '0 && !fifo_nonempty ? IDLE : DRAIN) :
                 (resp_ready ? IDLE : ERR);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      raddr <= '0;
      rem <= '0;
      vp <= '0;
      lp <= '0;
    end else begin
      vp <= (vp << 1) | READ_LATENCY'(issue);
      lp <= (lp << 1) | READ_LATENCY'(issue && rem == '0);
      if (accept && !range_err) begin
        raddr <= req_addr;
        rem <= req_len;
      end else if (issue && rem != '0) begin
        raddr <= raddr + 16'd1;
        rem <= rem - 8'd1;
      end
    end
  end
`ifdef STATS_READER_CLR_EN
  // Beats leave in address order, so a running address tracks the popped beat.
  logic [STATS_ADDR_W-1:0] out_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr <= '0;
      clr_valid <= 1'b0;
      clr_addr <= '0;
    end else begin
      clr_valid <= pop;
      clr_addr <= out_addr;
      if (accept) out_addr <= req_addr;
      else if (pop) out_addr <= out_addr + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stats_reader.sv
// tb_stats_reader: directed checks of stats_reader with a 2-cycle-latency counter memory model.
module tb_stats_reader;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, resp_valid, resp_ready, resp_last, resp_err;
  logic [15:0] req_addr, raddr, pre;
  logic [7:0] req_len;
  logic [31:0] rdata, rd1, resp_data;
  logic [31:0] mem [1024];
  logic fill = 1'b1;
  logic cleared42 = 1'b0;
  int vectors = 0;
  int miscompares = 0;
`ifdef STATS_READER_CLR_EN
  logic clr_valid;
  logic [15:0] clr_addr;
  int clr_n = 0;
  logic [15:0] clr_seen = 16'd0;
`endif

  always #5 clk = ~clk;

  stats_reader dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .raddr(raddr), .rdata(rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err)
`ifdef STATS_READER_CLR_EN
    , .clr_valid(clr_valid), .clr_addr(clr_addr)
`endif
  );

  function automatic logic [31:0] exp_val(input int a);
    return a == 42 ? (cleared42 ? 32'd0 : 32'd7) : 32'hC000_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) mem[i] <= exp_val(i);
    rd1 <= mem[raddr[9:0]];
    rdata <= rd1;
`ifdef STATS_READER_CLR_EN
    if (clr_valid) begin
      mem[clr_addr[9:0]] <= 32'd0;
      clr_n <= clr_n + 1;
      clr_seen <= clr_addr;
    end
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int l);
    req_addr = 16'(a);
    req_len = 8'(l);
    req_valid = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle", req_ready, 1);
    chk("idle_no_valid", resp_valid, 0);
  endtask

  // mode 0: ready held high; mode 1: toggling, then 10 low cycles, then high
  task automatic collect(input int base, input int n, input int mode, input int stop);
    int cnt = 0, first = -1, lastk = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    for (int k = 1; k <= 300 && cnt < n; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      resp_ready = mode == 0 ? 1'b1 : (k <= 20 ? k % 2 == 1 : k > 30);
      if (pv && !pr) begin
        chk("stall_valid", resp_valid, 1);
        chk("stall_data", resp_data, pd);
      end
      if (resp_valid && resp_ready) begin
        chk("data", resp_data, exp_val(base + cnt));
        chk("last", resp_last, cnt == n - 1);
        chk("err", resp_err, 0);
        if (first < 0) first = k;
        lastk = k;
        cnt++;
        if (cnt == stop) return;
      end
      pv = resp_valid;
      pr = resp_ready;
      pd = resp_data;
    end
    chk("beat_count", cnt, n);
    if (mode == 0) begin
      chk("first_latency", first, 4);
      chk("no_bubbles", lastk - first, n - 1);
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; resp_ready = 1'b0;
    @(negedge clk);
    fill = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_last", resp_last, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_data", resp_data, 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);
    // single read of address 42
    resp_ready = 1'b1;
    send(42, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("single_raddr", raddr, 42);
    chk("busy_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("single_early", resp_valid, 0);
    @(negedge clk);
    chk("single_valid", resp_valid, 1);
    chk("single_data", resp_data, 7);
    chk("single_last", resp_last, 1);
    chk("single_err", resp_err, 0);
    @(negedge clk);
    chk("single_done", resp_valid, 0);
    wait_idle();
`ifdef STATS_READER_CLR_EN
    chk("clr_count", clr_n, 1);
    chk("clr_addr", clr_seen, 42);
`endif
    // 24-word burst ending exactly at the last counter
    send(1000, 23);
    collect(1000, 24, 0, 0);
    wait_idle();
    // range errors
    pre = raddr;
    resp_ready = 1'b0;
    send(1020, 4);
    @(negedge clk);
    req_valid = 1'b0;
    chk("err_valid", resp_valid, 1);
    chk("err_flag", resp_err, 1);
    chk("err_last", resp_last, 1);
    chk("err_data", resp_data, 0);
    chk("err_busy", req_ready, 0);
    @(negedge clk);
    chk("err_hold", resp_err, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("err_done", resp_valid, 0);
    chk("err_no_raddr", raddr, pre);
    send(1000, 24);
    @(negedge clk);
    req_valid = 1'b0;
    chk("over_by_one_err", resp_err, 1);
    wait_idle();
    send(16'hFFFF, 255);
    @(negedge clk);
    req_valid = 1'b0;
    chk("nowrap_err", resp_err, 1);
    wait_idle();
    chk("err_raddr_kept", raddr, pre);
    // backpressure
    send(100, 15);
    collect(100, 16, 1, 0);
    wait_idle();
    // reset on beat 5 of a 32-word burst
    resp_ready = 1'b1;
    send(200, 31);
    collect(200, 32, 0, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_raddr", raddr, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_last", resp_last, 0);
    chk("mid_rst_ready", req_ready, 0);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("no_beats_after_reset", seen, 0);
    send(300, 2);
    collect(300, 3, 0, 0);
    wait_idle();
`ifdef STATS_READER_CLR_EN
    cleared42 = 1'b1;
    send(42, 0);
    collect(42, 1, 0, 0);
    wait_idle();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
